// File: rtl/cnn_pkg.sv
// Shared types for the CNN streaming front end.
// Holds the pixel streamer's FSM state encoding.
package cnn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        DONE
    } stream_state_e;

endpackage

// File: rtl/pixel_buffer.sv
// Frame buffer: Depth x BitSize registers, one write port,
// one combinational read port. Contents survive reset.
module pixel_buffer #(
    parameter int BitSize = 32,
    parameter int Depth   = 64,
    localparam int AW     = $clog2(Depth)
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [BitSize-1:0] wr_data,
    input  logic [AW-1:0]      rd_addr,
    output logic [BitSize-1:0] rd_data
);

    logic [BitSize-1:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pixel_streamer.sv
// Streams a buffered frame to a valid/ready sink and waits
// for the sink's frame-complete acknowledge.
module pixel_streamer
    import cnn_pkg::*;
#(
    parameter int BitSize    = 32,
    parameter int ImageWidth = 8,
    localparam int Depth     = ImageWidth * ImageWidth,
    localparam int AW        = $clog2(Depth)
) (
    input  logic               clk,
    input  logic               res,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [BitSize-1:0] wr_data,
    input  logic               start,
    input  logic               sink_ready,
    input  logic               sink_done,
    output logic               out_valid,
    output logic [BitSize-1:0] out_data,
    output logic               busy,
    output logic               frame_done,
    output logic               wr_reject,
    output logic               proto_err
);

    localparam logic [AW-1:0] LastIdx = AW'(Depth - 1);

    stream_state_e      state, state_nxt;
    logic [AW-1:0]      idx, idx_nxt;
    logic               buf_we;
    logic [BitSize-1:0] rd_data;

    pixel_buffer #(
        .BitSize (BitSize),
        .Depth   (Depth)
    ) u_buf (
        .clk     (clk),
        .wr_en   (buf_we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (idx),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (res) begin
            state     <= IDLE;
            idx       <= '0;
            wr_reject <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            wr_reject <= wr_en && (state != IDLE);
            // An acknowledge before the last pixel left is a sink bug.
            if (state == STREAM && sink_done) begin
                proto_err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        buf_we    = 1'b0;
        unique case (state)
            IDLE: begin
                buf_we = wr_en;
                if (start) begin
                    state_nxt = STREAM;
                    idx_nxt   = '0;
                end
            end
            STREAM: begin
                if (sink_ready) begin
                    if (idx == LastIdx) begin
                        idx_nxt   = '0;
                        state_nxt = DRAIN;
                    end else begin
                        idx_nxt = idx + AW'(1);
                    end
                end
            end
            DRAIN: begin
                if (sink_done) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign out_valid  = (state == STREAM);
    assign out_data   = out_valid ? rd_data : '0;
    assign busy       = (state != IDLE);
    assign frame_done = (state == DONE);

endmodule
